// File: rtl/t_pulse_gen.sv
// Debounces a raw push-button into a single-cycle toggle pulse (t_out), a debounced level and a press count.
// Latency: t_out/btn_level change DEBOUNCE_CYCLES+2 edges after a clean input edge; no backpressure (fire-and-forget pulse).
module t_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       en,
  output logic       t_out,
  output logic       btn_level,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, ARM_HI, HIGH, ARM_LO} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             s1, s2;
  logic             t_n, level_n;
  logic [7:0]       count_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      t_out       <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      s1          <= btn_in;
      s2          <= s1;
      state       <= state_n;
      cnt         <= cnt_n;
      t_out       <= t_n;
      btn_level   <= level_n;
      press_count <= count_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    t_n     = 1'b0;
    level_n = btn_level;
    count_n = press_count;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (s2) begin
          cnt_n   = CNT_W'(1);
          state_n = ARM_HI;
        end
      end
      ARM_HI: begin
        if (!s2) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == LAST) begin
          // en is only looked at here; a press taken while disabled is consumed.
          cnt_n   = '0;
          state_n = HIGH;
          level_n = 1'b1;
          t_n     = en;
          if (en) count_n = press_count + 8'd1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        cnt_n = '0;
        if (!s2) begin
          cnt_n   = CNT_W'(1);
          state_n = ARM_LO;
        end
      end
      ARM_LO: begin
        if (s2) begin
          cnt_n   = '0;
          state_n = HIGH;
        end else if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: doc/t_pulse_gen.md
# t_pulse_gen

Upstream stage for the T flip-flop: turns a raw, bouncing, asynchronous push-button input into a clean single-cycle toggle-enable pulse (`t_out`) that drives the flip-flop's `t` input. It synchronises the input into the `clk` domain and debounces it with a 4-state FSM and counter. It also exports the debounced level and a wrapping press counter for status and debug.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to accept a level change; legal range 2..255.
- `CNT_W`, default 8: width of the debounce counter; must hold `DEBOUNCE_CYCLES`.

Ports:
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `btn_in` input, 1: raw button; asynchronous to `clk`; may bounce.
- `en` input, 1: pulse enable; when 0, `t_out` is suppressed and `press_count` is frozen.
- `t_out` output, 1: registered one-cycle pulse on each accepted press; connects to the flip-flop `t`.
- `btn_level` output, 1: registered debounced button level.
- `press_count` output, 8: number of emitted `t_out` pulses, modulo 256.

## Operation
- **Synchroniser.** Two-flop chain `btn_in -> s1 -> s2`. The FSM sees only `s2`.
- **FSM states:**
  - IDLE: stable low.
  - ARM_HI: candidate high.
  - HIGH: stable high.
  - ARM_LO: candidate low.
- **IDLE:**
  - `s2`=1: counter <= 1, go to ARM_HI.
  - Otherwise stay; counter = 0.
- **ARM_HI:**
  - `s2`=0: counter <= 0, return to IDLE; no output.
  - `s2`=1 and counter == `DEBOUNCE_CYCLES`-1: go to HIGH, `btn_level` <= 1, `t_out` <= `en`, counter <= 0.
  - Otherwise counter++.
- **HIGH:**
  - `s2`=0: counter <= 1, go to ARM_LO.
- **ARM_LO:** mirror of ARM_HI.
  - Abort back to HIGH if `s2`=1.
  - On completion, go to IDLE with `btn_level` <= 0.
  - No `t_out` on release.
- **Acceptance rule.** A level change is accepted only after exactly `DEBOUNCE_CYCLES` consecutive samples of `s2` at the new value. Any reverting sample restarts the count from the stable state.
- **`t_out` width.** High for exactly one cycle per accepted press, never two consecutive cycles.
- **`press_count`.** Increments in the same cycle `t_out` is 1. Wraps 255 -> 0 with no flag.
- **`en` behaviour.**
  - `en` is sampled only in the acceptance cycle.
  - `en`=0 there: FSM still moves to HIGH and `btn_level` still rises.
  - The press is then consumed. No late pulse follows if `en` rises while the button is held.

## Timing
- **Reset values:** `t_out`=0, `btn_level`=0, `press_count`=0, `s1`=`s2`=0, counter=0, state=IDLE.
- **Reset priority.** Reset overrides all other activity, including mid-ARM_HI/ARM_LO; an in-progress debounce is discarded.
- **Button held through reset release.** Treated as a fresh press. It produces one `t_out` after the normal latency.
- **Press latency.** Let `btn_in` rise (clean) before edge E0.
  - `s1`=1 at E0; `s2`=1 at E1.
  - FSM samples `s2`=1 at E2 .. E(1+`DEBOUNCE_CYCLES`).
  - `t_out`=1 and `btn_level`=1 after E(1+`DEBOUNCE_CYCLES`); `t_out` returns to 0 after the following edge.
  - With `DEBOUNCE_CYCLES`=4: the pulse appears after the 6th edge, counting E0 as the 1st.
- **Release latency.** Identical; `btn_level` falls `DEBOUNCE_CYCLES`+2 edges after a clean fall.
- **Filtering.** A glitch of fewer than `DEBOUNCE_CYCLES` cycles, as seen at `s2`, produces no output change.
- **Downstream contract.** The T flip-flop toggles exactly once per `t_out` pulse; no handshake back.

## Test plan
- **Clean press** (`DEBOUNCE_CYCLES`=4, `en`=1): raise `btn_in` before E0 and hold 20 cycles -> `t_out`=1 for exactly one cycle after E5; `btn_level`=1 from then on; `press_count`=1.
- **Bounce:** pulse `btn_in` high 2 cycles, low 1, high 3, low -> no `t_out`, `btn_level` stays 0, `press_count`=0.
- **Release:**
  - Hold high 20 cycles, then drop and hold low -> `btn_level` falls 6 edges after the drop, with no `t_out`.
  - Second press -> `press_count`=2.
- **`en` gating:** press with `en`=0, raise `en` while held -> `btn_level`=1, no `t_out`, `press_count`=0.
  - Release and press again with `en`=1 -> one `t_out`.
- **Reset:**
  - Assert `rst` one cycle during ARM_HI -> all outputs 0 the next cycle.
  - With `btn_in` still high after release of `rst` -> one `t_out` 6 edges later.
- **Wrap:** 256 clean presses -> `press_count` returns to 0 on the 256th pulse; 257th -> 1. Drive the T flip-flop model with `t_out` and check `q` toggles once per pulse.
